// File: rtl/clk_count_pkg.sv
// Shared definitions for the 4-bit LED counter family (up and down variants).
// The prescale default is also used by the down counter, so both show the same visible rate.
package clk_count_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CW_DEFAULT = 4;

  // 2*(33554432+1) cycles of the 100 MHz clock per count step
  localparam int PRESCALE_DEFAULT = 67108866;
  localparam int PW_DEFAULT       = 27;

endpackage

// File: rtl/clk_tick_gen.sv
// Prescaler that emits a single-cycle enable every PRESCALE clocks while running.
// Stopping or restarting throws away any partial count, so the next period is always full length.
module clk_tick_gen
  import clk_count_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PW       = PW_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick_en
);

  localparam logic [PW-1:0] TERMINAL = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (!run || restart || (presc == TERMINAL)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A terminal count that coincides with a restart is discarded
  assign tick_en = run && !restart && (presc == TERMINAL);

endmodule

// File: rtl/clk_tick_count_up.sv
// 4-bit up counter with run/stop, synchronous clear, parallel load and single-step.
// Increments come from the clk_tick_gen enable in RUN or from step in IDLE.
module clk_tick_count_up
  import clk_count_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PW       = PW_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          step,
  output logic [CW-1:0] counter_out,
  output logic          tick,
  output logic          wrap
);

  state_t state;
  logic   run;
  logic   restart;
  logic   tick_en;
  logic   step_inc;

  // The prescaler only advances while RUN is held; the edge that leaves RUN clears it
  assign run      = (state == RUN) && en;
  assign restart  = clr || load;
  assign step_inc = (state == IDLE) && step;

  clk_tick_gen #(
    .PRESCALE(PRESCALE),
    .PW      (PW)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .restart(restart),
    .tick_en(tick_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      counter_out <= '0;
      tick        <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;

      case (state)
        IDLE:    if (en)  state <= RUN;
        RUN:     if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase

      // clr beats load beats increment
      if (clr) begin
        counter_out <= '0;
      end else if (load) begin
        counter_out <= load_val;
      end else if (tick_en || step_inc) begin
        counter_out <= counter_out + CW'(1);
        tick        <= 1'b1;
        wrap        <= (counter_out == {CW{1'b1}});
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_count_up.sv
// Directed bench for clk_tick_count_up at PRESCALE=4: run/wrap sweep, a vector table for
// load/clr/stop/step cases, then asynchronous reset with a pulse in flight.
module tb_clk_tick_count_up;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       step;
  logic [3:0] counter_out;
  logic       tick;
  logic       wrap;

  int total;
  int bad;

  typedef struct {
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       step;
    logic [3:0] exp_cnt;
    logic       exp_tick;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  clk_tick_count_up #(
    .PRESCALE(4),
    .PW      (3),
    .CW      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .step       (step),
    .counter_out(counter_out),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic c, input logic l, input logic [3:0] lv,
                              input logic s, input logic [3:0] ec, input logic et, input logic ew);
    vec_t v;
    v.en = e; v.clr = c; v.load = l; v.load_val = lv; v.step = s;
    v.exp_cnt = ec; v.exp_tick = et; v.exp_wrap = ew;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge
  task automatic applyStimulus(input logic e, input logic c, input logic l,
                               input logic [3:0] lv, input logic s);
    @(negedge clk);
    en = e; clr = c; load = l; load_val = lv; step = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_cnt,
                             input logic exp_tick, input logic exp_wrap);
    total++;
    if (counter_out !== exp_cnt || tick !== exp_tick || wrap !== exp_wrap) begin
      bad++;
      $display("[TB] FAIL %s: got cnt=%h tick=%b wrap=%b, expected cnt=%h tick=%b wrap=%b",
               name, counter_out, tick, wrap, exp_cnt, exp_tick, exp_wrap);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'h0; step = 1'b0;

    // load E on a prescaler terminal, run through 15 -> 0 wrap, then clr+load and load alone
    vecs.push_back(mk(1, 0, 1, 4'hE, 0, 4'hE, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'hE, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'hF, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'hF, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 4'hA, 0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 4'h7, 0, 4'h7, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h7, 0, 0));
    // stop at prescaler=2 for 10 cycles, single step, held step, then re-enable with step ignored
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1, 4'h8, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1, 4'h9, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1, 4'hA, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'hA, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'hA, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 1, 4'hA, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 1, 4'hA, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'hA, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'hB, 1, 0));
    // load 8 and run to 9 so reset lands with tick high
    vecs.push_back(mk(1, 0, 1, 4'h8, 0, 4'h8, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h9, 1, 0));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // continuous run from edge 0: value steps every 4 edges, wrap at edge 64
    for (int k = 0; k < 68; k++) begin
      applyStimulus(1, 0, 0, 4'h0, 0);
      checkOutput($sformatf("run_edge%0d", k), 4'((k / 4) % 16),
                  (k > 0) && (k % 4 == 0), (k > 0) && (k % 64 == 0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].step);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_tick, vecs[i].exp_wrap);
    end

    // drop reset between edges while tick is high
    #2;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    checkOutput("async_reset", 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 4'h0, 0);
      checkOutput($sformatf("idle_after_reset%0d", i), 4'h0, 1'b0, 1'b0);
    end
    applyStimulus(0, 0, 1, 4'hF, 0);
    checkOutput("idle_load_f", 4'hF, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 4'h0, 1);
    checkOutput("step_wrap", 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 4'h0, 0);
      checkOutput($sformatf("rerun_edge%0d", k), (k == 4) ? 4'h1 : 4'h0, k == 4, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
